pi_txn_queue: RTL and testbench
===============================

// Module: pi_txn_queue
// PURPOSE
//  Posted-transaction queue between the Pi register interface and the 68000 bus
//  cycle engine. It captures Pi writes to REG_DATA, REG_ADDR_LO and REG_ADDR_HI,
//  and each REG_ADDR_HI write pushes one complete bus operation into a FIFO.
//  It issues queued operations in order to the bus engine over a valid/ready
//  handshake, and returns read data with busy/overflow status for REG_STATUS.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of two, 2..16
//  PTR_W      2   log2(DEPTH); pointer width
// PORTS
//  c200m        in   1   system clock (PI_CLK domain)
//  rst          in   1   asynchronous, active-high reset
//  wr_strobe    in   1   one-cycle pulse: synchronised rising edge of PI_WR
//  wr_reg       in   2   register select sampled with wr_strobe (0 DATA,1 ADDR_LO,2 ADDR_HI,3 STATUS)
//  wr_data      in   16  Pi data sampled with wr_strobe
//  ovf_clr      in   1   one-cycle pulse: clears the overflow flag
//  op_valid     out  1   head entry presented to the bus engine
//  op_ready     in   1   bus engine accepts the head entry (op_valid&&op_ready = issue)
//  op_addr      out  24  68000 address A[23:0]
//  op_rw        out  1   1 = read, 0 = write
//  op_uds_n     out  1   upper data strobe for this cycle
//  op_lds_n     out  1   lower data strobe for this cycle
//  op_wdata     out  16  write data
//  op_done      in   1   one-cycle pulse: the issued cycle has finished (S7->S0)
//  op_rdata     in   16  read data, valid with op_done
//  rd_data      out  16  last completed read data
//  rd_valid     out  1   rd_data holds the result of the most recent read
//  busy         out  1   queue non-empty or a cycle is in flight (drives PI_TXN_IN_PROGRESS)
//  full         out  1   count == DEPTH
//  overflow     out  1   sticky: a push was dropped
// BEHAVIOUR
//  Reset values: all outputs 0; FIFO empty; staging regs 0; in_flight 0.
//  Staging:
//   - wr_reg=0: data_stg <= wr_data.
//   - wr_reg=1: addr_stg[15:0] <= wr_data; rd_valid <= 0.
//  Push on wr_reg=2. The entry is:
//   - A[23:16] = wr_data[7:0]
//   - rw = wr_data[9]
//   - byte access if wr_data[8]: uds_n = A0, lds_n = !A0
//   - word access otherwise: uds_n = lds_n = 0
//   - wdata = data_stg
//   A0 is taken from addr_stg[0]. Staging regs persist across pushes.
//  wr_reg=3 is ignored by this block.
//  FIFO: count is 0..DEPTH; pointers wrap modulo DEPTH.
//   - Push when full and no pop in the same cycle: dropped, overflow <= 1.
//   - Push and pop in the same cycle when full: both happen; no overflow.
//   - Push into an empty queue: op_valid is asserted the next cycle (1-cycle latency).
//  Issue:
//   - op_valid = !empty && !in_flight. op_* outputs are registered from the head entry.
//   - op_* are stable while op_valid is high and op_ready is low.
//   - On issue: pop the head and set in_flight <= 1.
//  Completion, on op_done while in_flight:
//   - in_flight <= 0.
//   - If the issued op was a read: rd_data <= op_rdata, rd_valid <= 1.
//   - op_done while !in_flight is ignored.
//  Only one cycle is ever outstanding. Order is strictly FIFO, so reads observe prior writes.
//  busy = !empty || in_flight. It is registered and falls in the cycle after the final op_done.
//  overflow is cleared by ovf_clr. If ovf_clr and a dropped push occur in the same cycle, set wins.
//  Reset mid-operation: queue and in_flight are cleared immediately and op_valid drops.
//   The bus engine shares rst and aborts its own cycle.
// TESTING
//  1. Write DATA=0xBEEF, LO=0x1234, HI=0x0000 -> op_valid; addr 0x001234, rw 0,
//     uds_n=lds_n=0, wdata 0xBEEF.
//  2. LO=0x0005, HI=0x0312 (byte read), op_done with op_rdata=0x00AA
//     -> op_addr 0x120005, uds_n 1, lds_n 0; rd_data 0x00AA, rd_valid 1, busy falls.
//  3. Hold op_ready=0 and push DEPTH+1 writes -> full=1, fifth push dropped, overflow=1;
//     then drain -> exactly 4 issues in push order.
//  4. Full queue with pop and push in the same cycle -> count stays DEPTH, overflow stays 0,
//     new entry issues last.
//  5. Three writes followed by a read, op_ready=1 with op_done 10 cycles after each issue
//     -> never two issues without an intervening op_done; read issues 4th.
//  6. Assert rst while in_flight with 2 entries queued -> op_valid, busy and full at 0
//     asynchronously; a later op_done has no effect.

Source files
------------

// File: rtl/pi_txn_queue.sv
// Posted-transaction queue between the Pi register interface and the 68000 bus engine.
// Stages DATA/ADDR_LO writes, pushes an operation on each ADDR_HI write, and issues one operation at a time.
module pi_txn_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        c200m,
  input  logic        rst,
  input  logic        wr_strobe,
  input  logic [1:0]  wr_reg,
  input  logic [15:0] wr_data,
  input  logic        ovf_clr,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [23:0] op_addr,
  output logic        op_rw,
  output logic        op_uds_n,
  output logic        op_lds_n,
  output logic [15:0] op_wdata,
  input  logic        op_done,
  input  logic [15:0] op_rdata,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_ADDR_LO = 2'd1,
    REG_ADDR_HI = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic [23:0] addr;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [15:0] wdata;
  } entry_t;

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  reg_sel_e         sel;
  logic [15:0]      data_stg;
  logic [15:0]      addr_stg;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_after_pop;
  logic [PTR_W:0]   count_next;
  logic             in_flight;
  logic             in_flight_next;
  logic             inflight_rw;
  logic             push;
  logic             push_ok;
  logic             drop;
  logic             issue;
  logic             done;
  entry_t           new_entry;
  entry_t           head_next;
  entry_t           op_q;

  assign sel     = reg_sel_e'(wr_reg);
  assign push    = wr_strobe && (sel == REG_ADDR_HI);
  assign issue   = op_valid && op_ready;
  assign done    = op_done && in_flight;
  assign full    = (count == DEPTH_CNT);
  // A pop in the same cycle frees the slot, so a push into a full queue survives.
  assign push_ok = push && (!full || issue);
  assign drop    = push && full && !issue;

  always_comb begin
    new_entry.addr  = {wr_data[7:0], addr_stg};
    new_entry.rw    = wr_data[9];
    new_entry.uds_n = wr_data[8] && addr_stg[0];
    new_entry.lds_n = wr_data[8] && !addr_stg[0];
    new_entry.wdata = data_stg;
  end

  // NOTE: every signal written in always_comb gets a value on every path (defaults first), so no latch is inferred.
  always_comb begin
    in_flight_next  = in_flight;
    count_after_pop = count - {{PTR_W{1'b0}}, issue};
    count_next      = count_after_pop + {{PTR_W{1'b0}}, push_ok};
    rd_ptr_next     = issue ? rd_ptr + PTR_ONE : rd_ptr;
    if (issue) begin
      in_flight_next = 1'b1;
    end else if (done) begin
      in_flight_next = 1'b0;
    end
    // When the queue drains to empty this cycle, the entry being pushed becomes the head.
    head_next = (count_after_pop == '0) ? new_entry : mem[rd_ptr_next];
  end

  // NOTE: the entry array has no reset; count alone says which slots hold live data.
  always_ff @(posedge c200m) begin
    if (push_ok) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge c200m or posedge rst) begin
    if (rst) begin
      data_stg    <= '0;
      addr_stg    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_flight   <= 1'b0;
      inflight_rw <= 1'b0;
      op_valid    <= 1'b0;
      op_q        <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_strobe) begin
        case (sel)
          REG_DATA: data_stg <= wr_data;
          REG_ADDR_LO: begin
            addr_stg <= wr_data;
            rd_valid <= 1'b0;
          end
          default: ;
        endcase
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      in_flight <= in_flight_next;
      if (issue) begin
        inflight_rw <= op_q.rw;
      end
      // A completing read outranks a same-cycle ADDR_LO write for rd_valid.
      if (done && inflight_rw) begin
        rd_data  <= op_rdata;
        rd_valid <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      op_valid <= (count_next != '0) && !in_flight_next;
      busy     <= (count_next != '0) || in_flight_next;
      if (count_next != '0) begin
        op_q <= head_next;
      end
    end
  end

  assign op_addr  = op_q.addr;
  assign op_rw    = op_q.rw;
  assign op_uds_n = op_q.uds_n;
  assign op_lds_n = op_q.lds_n;
  assign op_wdata = op_q.wdata;

endmodule

// File: tb/tb_pi_txn_queue.sv
// Self-checking bench for pi_txn_queue: queue-based reference model, bus-engine responder,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pi_txn_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        c200m = 1'b0;
  logic        rst;
  logic        wr_strobe = 1'b0;
  logic [1:0]  wr_reg = 2'd0;
  logic [15:0] wr_data = 16'd0;
  logic        ovf_clr = 1'b0;
  logic        op_valid;
  logic        op_ready;
  logic [23:0] op_addr;
  logic        op_rw;
  logic        op_uds_n;
  logic        op_lds_n;
  logic [15:0] op_wdata;
  logic        op_done = 1'b0;
  logic [15:0] op_rdata = 16'd0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        full;
  logic        overflow;

  pi_txn_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .c200m(c200m), .rst(rst), .wr_strobe(wr_strobe), .wr_reg(wr_reg), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .op_valid(op_valid), .op_ready(op_ready), .op_addr(op_addr),
    .op_rw(op_rw), .op_uds_n(op_uds_n), .op_lds_n(op_lds_n), .op_wdata(op_wdata),
    .op_done(op_done), .op_rdata(op_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 c200m = ~c200m;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench controls: ready_mode 0 = never ready, 1 = always, 2 = random, 3 = manual_ready.
  int          ready_mode = 0;
  logic        manual_ready = 1'b0;
  logic        eng_ready = 1'b0;
  int          done_delay = 2;
  bit          rand_delay = 1'b0;
  bit          spurious = 1'b0;
  bit          force_rd = 1'b0;
  logic [15:0] force_val = 16'd0;
  bit          cmp_en = 1'b0;

  assign op_ready = (ready_mode == 3) ? manual_ready : eng_ready;

  // Reference model: a queue of operations plus one outstanding-cycle flag.
  typedef struct {
    logic [23:0] addr;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [15:0] wdata;
  } ent_t;

  ent_t        mq[$];
  bit          m_inf = 1'b0;
  bit          m_rw = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_rdv = 1'b0;
  logic [15:0] m_rd = 16'd0;
  logic [15:0] m_dstg = 16'd0;
  logic [15:0] m_astg = 16'd0;
  int          m_issues = 0;

  always @(posedge c200m or posedge rst) begin : model_p
    ent_t e;
    bit   can_issue;
    if (rst) begin
      mq.delete();
      m_inf  = 1'b0;
      m_rw   = 1'b0;
      m_ovf  = 1'b0;
      m_rdv  = 1'b0;
      m_rd   = 16'd0;
      m_dstg = 16'd0;
      m_astg = 16'd0;
    end else begin
      can_issue = (mq.size() > 0) && !m_inf;
      if (wr_strobe && wr_reg == 2'd0) m_dstg = wr_data;
      if (wr_strobe && wr_reg == 2'd1) begin
        m_astg = wr_data;
        m_rdv  = 1'b0;
      end
      if (op_done && m_inf) begin
        m_inf = 1'b0;
        if (m_rw) begin
          m_rd  = op_rdata;
          m_rdv = 1'b1;
        end
      end
      if (can_issue && op_ready) begin
        e = mq.pop_front();
        m_inf = 1'b1;
        m_rw  = e.rw;
        m_issues++;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (wr_strobe && wr_reg == 2'd2) begin
        e.addr  = {wr_data[7:0], m_astg};
        e.rw    = wr_data[9];
        e.uds_n = wr_data[8] ? m_astg[0] : 1'b0;
        e.lds_n = wr_data[8] ? !m_astg[0] : 1'b0;
        e.wdata = m_dstg;
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge c200m) begin
    if (cmp_en) begin
      check("op_valid", op_valid, (mq.size() > 0) && !m_inf);
      check("busy", busy, (mq.size() > 0) || m_inf);
      check("full", full, mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      check("rd_valid", rd_valid, m_rdv);
      check("rd_data", rd_data, m_rd);
      if ((mq.size() > 0) && !m_inf) begin
        check("op_addr", op_addr, mq[0].addr);
        check("op_rw", op_rw, mq[0].rw);
        check("op_uds_n", op_uds_n, mq[0].uds_n);
        check("op_lds_n", op_lds_n, mq[0].lds_n);
        check("op_wdata", op_wdata, mq[0].wdata);
      end
    end
  end

  // Bus-engine responder: one op_done per issue after a programmable delay.
  int eng_seen = 0;
  bit eng_pend = 1'b0;
  int eng_cnt = 0;

  always @(negedge c200m) begin
    op_done = 1'b0;
    if (m_issues != eng_seen) begin
      eng_seen = m_issues;
      eng_pend = 1'b1;
      eng_cnt  = rand_delay ? int'($urandom_range(0, 4)) : done_delay;
    end
    if (eng_pend) begin
      if (eng_cnt == 0) begin
        op_done  = 1'b1;
        op_rdata = force_rd ? force_val : 16'($urandom);
        eng_pend = 1'b0;
      end else begin
        eng_cnt--;
      end
    end else if (spurious && $urandom_range(0, 7) == 0) begin
      op_done  = 1'b1;
      op_rdata = 16'($urandom);
    end
    eng_ready = (ready_mode == 1) ? 1'b1 :
                (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  // Issue log taken from the DUT pins, plus a check that issues never overlap.
  logic [24:0] dlog[$];
  bit          outstanding = 1'b0;
  int          overlap_viol = 0;

  always @(posedge c200m or posedge rst) begin
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (op_done) outstanding = 1'b0;
      if (op_valid && op_ready) begin
        if (outstanding) overlap_viol++;
        outstanding = 1'b1;
        dlog.push_back({op_rw, op_addr});
      end
    end
  end

  task automatic tick();
    @(negedge c200m);
  endtask

  task automatic pi_write(input logic [1:0] r, input logic [15:0] d);
    wr_strobe = 1'b1;
    wr_reg    = r;
    wr_data   = d;
    @(negedge c200m);
    wr_strobe = 1'b0;
  endtask

  task automatic push_op(input logic [23:0] a, input logic rw, input logic byte_acc,
                         input logic [15:0] wd);
    pi_write(2'd0, wd);
    pi_write(2'd1, a[15:0]);
    pi_write(2'd2, {6'd0, rw, byte_acc, a[23:16]});
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    tick();
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, n < max_cycles, 1'b1);
  endtask

  initial begin
    int          base;
    logic [24:0] ent;
    rst = 1'b1;
    repeat (2) tick();
    check("rst_op_valid", op_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_op_addr", op_addr, 24'h000000);
    check("rst_op_wdata", op_wdata, 16'h0000);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Word write.
    pi_write(2'd0, 16'hBEEF);
    pi_write(2'd1, 16'h1234);
    pi_write(2'd2, 16'h0000);
    check("t1_op_valid", op_valid, 1'b1);
    check("t1_op_addr", op_addr, 24'h001234);
    check("t1_op_rw", op_rw, 1'b0);
    check("t1_strobes", {op_uds_n, op_lds_n}, 2'b00);
    check("t1_op_wdata", op_wdata, 16'hBEEF);
    check("t1_busy", busy, 1'b1);
    ready_mode = 1;
    wait_idle("t1_idle_timeout", 50);

    // Byte read at an odd address.
    ready_mode = 0;
    force_rd = 1'b1;
    force_val = 16'h00AA;
    tick();
    pi_write(2'd1, 16'h0005);
    pi_write(2'd2, 16'h0312);
    check("t2_op_addr", op_addr, 24'h120005);
    check("t2_op_rw", op_rw, 1'b1);
    check("t2_strobes", {op_uds_n, op_lds_n}, 2'b10);
    ready_mode = 1;
    wait_idle("t2_idle_timeout", 50);
    check("t2_rd_data", rd_data, 16'h00AA);
    check("t2_rd_valid", rd_valid, 1'b1);
    check("t2_busy", busy, 1'b0);
    force_rd = 1'b0;

    // Overflow with the engine stalled, then drain in order.
    ready_mode = 0;
    repeat (2) tick();
    base = dlog.size();
    for (int i = 0; i < DEPTH; i++) push_op(24'h0A0100 + 24'(i), 1'b0, 1'b0, 16'h1000 + 16'(i));
    check("t3_full", full, 1'b1);
    check("t3_no_overflow_yet", overflow, 1'b0);
    push_op(24'h0A01FF, 1'b0, 1'b0, 16'h1FFF);
    check("t3_overflow", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", overflow, 1'b0);
    pi_write(2'd0, 16'h2FFF);
    pi_write(2'd1, 16'h01FE);
    ovf_clr = 1'b1;
    pi_write(2'd2, 16'h000A);
    ovf_clr = 1'b0;
    check("t3_set_wins", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ready_mode = 1;
    wait_idle("t3_idle_timeout", 100);
    check("t3_issue_count", dlog.size() - base, DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      ent = dlog[base + k];
      check("t3_issue_order", ent[23:0], 24'h0A0100 + 24'(k));
    end

    // Push and pop in the same cycle on a full queue.
    ready_mode = 3;
    manual_ready = 1'b0;
    tick();
    base = dlog.size();
    for (int i = 0; i < DEPTH; i++) push_op(24'h0B0200 + 24'(i), 1'b0, 1'b0, 16'h3000 + 16'(i));
    check("t4_full_before", full, 1'b1);
    pi_write(2'd0, 16'hC0DE);
    pi_write(2'd1, 16'h0277);
    manual_ready = 1'b1;
    pi_write(2'd2, 16'h000B);
    manual_ready = 1'b0;
    check("t4_full_after", full, 1'b1);
    check("t4_no_overflow", overflow, 1'b0);
    ready_mode = 1;
    wait_idle("t4_idle_timeout", 100);
    check("t4_issue_count", dlog.size() - base, DEPTH + 1);
    ent = dlog[base];
    check("t4_first_issue", ent[23:0], 24'h0B0200);
    ent = dlog[base + DEPTH];
    check("t4_last_issue", ent[23:0], 24'h0B0277);

    // Long completion latency: one outstanding cycle at a time, read issues fourth.
    done_delay = 10;
    base = dlog.size();
    for (int i = 0; i < 3; i++) push_op(24'h0C0300 + 24'(i), 1'b0, 1'b0, 16'h4000 + 16'(i));
    push_op(24'h0C0300, 1'b1, 1'b0, 16'h0000);
    wait_idle("t5_idle_timeout", 200);
    check("t5_issue_count", dlog.size() - base, 4);
    ent = dlog[base + 3];
    check("t5_fourth_is_read", ent[24], 1'b1);
    ent = dlog[base + 2];
    check("t5_third_is_write", ent[24], 1'b0);
    check("t5_no_overlap", overlap_viol, 0);

    // Asynchronous reset with a cycle in flight and two entries queued.
    ready_mode = 0;
    done_delay = 8;
    tick();
    push_op(24'h0D0001, 1'b1, 1'b1, 16'h5555);
    push_op(24'h0D0002, 1'b0, 1'b0, 16'h6666);
    push_op(24'h0D0004, 1'b0, 1'b0, 16'h7777);
    ready_mode = 3;
    manual_ready = 1'b1;
    tick();
    manual_ready = 1'b0;
    check("t6_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_op_valid", op_valid, 1'b0);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_full", full, 1'b0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check("t6_late_done_busy", busy, 1'b0);
    check("t6_late_done_rd_valid", rd_valid, 1'b0);
    check("t6_late_done_op_valid", op_valid, 1'b0);

    // Randomized traffic against the model.
    ready_mode = 2;
    rand_delay = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr_strobe = 1'b1;
        wr_reg    = 2'($urandom_range(0, 3));
        wr_data   = 16'($urandom);
      end else begin
        wr_strobe = 1'b0;
      end
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    wr_strobe = 1'b0;
    ovf_clr = 1'b0;
    spurious = 1'b0;
    ready_mode = 1;
    wait_idle("rand_idle_timeout", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
